// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, STATUS bit positions and FSM encoding for mmio_uart_tx
package uart_pkg;
   localparam logic [2:0] TXDATA_OFF = 3'd0;
   localparam logic [2:0] STATUS_OFF = 3'd4;
   localparam int ST_BUSY  = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_EMPTY = 2;
   localparam int ST_OVF   = 3;
   localparam int ST_CNT   = 8;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with fall-through read data and occupancy count
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0] cnt_q, cnt_d;
   logic do_push, do_pop;
   assign full  = cnt_q == CW'(DEPTH);
   assign empty = cnt_q == '0;
   assign count = cnt_q;
   assign dout  = mem_q[rd_q];
   // a pop in the same cycle frees a slot, so a push into a full FIFO is still accepted
   always_comb begin
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      mem_d   = mem_q;
      if (do_push) mem_d[wr_q] = din;
      wr_d  = do_push ? wr_q + 1'b1 : wr_q;
      rd_d  = do_pop ? rd_q + 1'b1 : rd_q;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO and STATUS register
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_2000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd,
   input  logic [3:0]  we,
   input  logic [31:0] addr_in,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        hit,
   output logic        tx,
   output logic        tx_busy
);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   state_t state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d, fifo_dout;
   logic [31:0] dout_q, dout_d, status;
   logic [CW-1:0] count;
   logic tx_q, tx_d, ovf_q, ovf_d;
   logic sel_status, push, pop, full, empty, baud_last;
   logic unused_ok;
   assign unused_ok  = ^{we[3:1], addr_in[1:0], data_in[31:8]};
   assign hit        = addr_in[31:3] == BASE_ADDR[31:3];
   assign sel_status = addr_in[2] == STATUS_OFF[2];
   assign push       = hit && addr_in[2] == TXDATA_OFF[2] && we[0];
   assign baud_last  = baud_q == BW'(CLKS_PER_BIT - 1);
   assign data_out   = dout_q;
   assign tx         = tx_q;
   assign tx_busy    = state_q != IDLE;
   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (data_in[7:0]),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty),
      .count (count)
   );
   always_comb begin
      status           = '0;
      status[ST_BUSY]  = state_q != IDLE;
      status[ST_FULL]  = full;
      status[ST_EMPTY] = empty;
      status[ST_OVF]   = ovf_q;
      status[ST_CNT +: CW] = count;
      dout_d = (hit && rd && sel_status) ? status : '0;
      ovf_d  = ovf_q;
      if (push && full && !pop) ovf_d = 1'b1;
      else if (hit && sel_status && we[0] && data_in[ST_OVF]) ovf_d = 1'b0;
   end
   // tx_d is the line level for the cycle after the edge, so transitions load it directly
   always_comb begin
      state_d = state_q;
      baud_d  = baud_last ? '0 : baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            tx_d   = empty;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = fifo_dout;
               state_d = START;
            end
         end
         START: if (baud_last) begin
            state_d = DATA;
            bit_d   = '0;
            tx_d    = shift_q[0];
         end
         DATA: if (baud_last) begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + 1'b1;
            if (bit_q == 3'd7) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
         STOP: if (baud_last) begin
            tx_d = empty;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = fifo_dout;
               state_d = START;
            end else state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         ovf_q   <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         ovf_q   <= ovf_d;
         dout_q  <= dout_d;
      end
   end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed and random checks of mmio_uart_tx against a frame-timing model
module tb_mmio_uart_tx;
   localparam int C = 4, D = 4, FR = 10 * C, NT = 16384;
   localparam logic [31:0] BASE = 32'h2000;
   logic clk = 1'b0, rst = 1'b1, rd = 1'b0;
   logic [3:0] we = '0;
   logic [31:0] addr_in = '0, data_in = '0, data_out;
   logic hit, tx, tx_busy;
   int cyc = 0, n_assert = 0, n_fail = 0, win = 0;
   logic trace_tx [NT];
   logic trace_busy [NT];
   int pops[$], pushes[$];
   logic [7:0] bytes[$];
   bit ovf = 1'b0;
   int t0, p, r, last;

   mmio_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .rd(rd), .we(we), .addr_in(addr_in), .data_in(data_in),
      .data_out(data_out), .hit(hit), .tx(tx), .tx_busy(tx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (cyc < NT) begin
      trace_tx[cyc] <= tx;
      trace_busy[cyc] <= tx_busy;
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Line level after edge c: every accepted byte occupies [pop, pop+FR) as start, 8 data, stop.
   function automatic logic exp_tx(int c);
      int seg;
      foreach (pops[j]) if (c >= pops[j] && c < pops[j] + FR) begin
         seg = (c - pops[j]) / C;
         return seg == 0 ? 1'b0 : seg == 9 ? 1'b1 : bytes[j][seg-1];
      end
      return 1'b1;
   endfunction
   function automatic logic exp_busy(int c);
      foreach (pops[j]) if (c >= pops[j] && c < pops[j] + FR) return 1'b1;
      return 1'b0;
   endfunction
   function automatic logic [31:0] exp_status(int s);
      int n;
      logic busy;
      n = 0;
      busy = 1'b0;
      foreach (pops[j]) begin
         if (pushes[j] <= s && pops[j] > s) n++;
         if (pops[j] <= s && s < pops[j] + FR) busy = 1'b1;
      end
      return {16'd0, 8'(n), 4'd0, ovf, n == 0, n == D, busy};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic wait_until(input int t);
      while (cyc < t) step(1);
   endtask
   task automatic push_byte(input logic [7:0] b);
      int t, n, pp;
      addr_in = BASE;
      we = 4'b0001;
      data_in = {24'($urandom), b};
      step(1);
      we = '0;
      addr_in = '0;
      t = cyc;
      n = 0;
      foreach (pops[j]) if (pops[j] > t) n++;
      if (n < D) begin
         pp = t + 1;
         if (pops.size() > 0 && pops[$] + FR > pp) pp = pops[$] + FR;
         pops.push_back(pp);
         pushes.push_back(t);
         bytes.push_back(b);
      end else ovf = 1'b1;
   endtask
   task automatic w1c();
      addr_in = BASE + 32'h4;
      we = 4'b0001;
      data_in = 32'h8;
      step(1);
      we = '0;
      addr_in = '0;
      ovf = 1'b0;
   endtask
   task automatic read_status(input string tag);
      addr_in = BASE + 32'h4;
      rd = 1'b1;
      step(1);
      rd = 1'b0;
      addr_in = '0;
      chk(tag, data_out, exp_status(cyc - 1));
   endtask
   task automatic check_window(input string tag);
      int bad, first;
      bad = 0;
      first = -1;
      for (int c = win; c < cyc; c++)
         if (trace_tx[c] !== exp_tx(c) || trace_busy[c] !== exp_busy(c)) begin
            bad++;
            if (first < 0) first = c;
         end
      n_assert++;
      assert (bad === 0) else begin
         n_fail++;
         $error("FAIL %s: %0d wrong cycles, first at %0d (tx=%b busy=%b, required tx=%b busy=%b)",
                tag, bad, first, trace_tx[first], trace_busy[first], exp_tx(first), exp_busy(first));
      end
      win = cyc;
   endtask
   task automatic drain();
      last = pops.size() > 0 ? pops[$] + FR : cyc;
      wait_until((last > cyc ? last : cyc) + 3);
   endtask

   initial begin
      step(3);
      chk("reset_tx", 32'(tx), 32'd1);
      chk("reset_busy", 32'(tx_busy), 32'd0);
      chk("reset_dout", data_out, 32'd0);
      rst = 1'b0;
      win = cyc;
      read_status("idle_status");
      chk("idle_status_const", data_out, 32'h4);

      push_byte(8'hA5);
      chk("a5_tx_hold", 32'(tx), 32'd1);
      step(1);
      chk("a5_tx_fall", 32'(tx), 32'd0);
      step(FR - 1);
      chk("a5_busy_last", 32'(tx_busy), 32'd1);
      step(1);
      chk("a5_busy_drop", 32'(tx_busy), 32'd0);
      step(5);
      check_window("a5_frame");

      push_byte(8'h11);
      t0 = cyc;
      push_byte(8'h22);
      push_byte(8'h33);
      for (int k = 0; k < 3; k++) begin
         wait_until(t0 + 9 + FR * k);
         read_status("burst_status");
         chk("burst_count", 32'(data_out[15:8]), 32'(2 - k));
      end
      drain();
      check_window("burst_frames");

      for (int k = 0; k < 6; k++) push_byte(8'($urandom));
      read_status("ovf_status");
      chk("ovf_status_const", data_out, 32'h0000_040B);
      w1c();
      read_status("ovf_cleared_status");
      chk("ovf_cleared_bit", 32'(data_out[3]), 32'd0);
      drain();
      check_window("ovf_frames");

      read_status("idle_status2");
      chk("idle_status2_const", data_out, 32'h4);
      addr_in = BASE;
      rd = 1'b1;
      #1 chk("hit_txdata", 32'(hit), 32'd1);
      step(1);
      chk("txdata_read", data_out, 32'd0);
      addr_in = 32'h3000;
      #1 chk("miss_hit", 32'(hit), 32'd0);
      step(1);
      rd = 1'b0;
      chk("miss_read", data_out, 32'd0);
      addr_in = '0;

      push_byte(8'h5A);
      push_byte(8'hC3);
      push_byte(8'h0F);
      p = pops[0];
      wait_until(p + 4 * C + 1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check_window("pre_reset_frame");
      pops.delete();
      pushes.delete();
      bytes.delete();
      ovf = 1'b0;
      chk("rst_mid_tx", 32'(tx), 32'd1);
      chk("rst_mid_busy", 32'(tx_busy), 32'd0);
      read_status("rst_mid_status");
      chk("rst_mid_status_const", data_out, 32'h4);
      step(100);
      check_window("post_reset_idle");

      addr_in = BASE;
      we = 4'b0010;
      data_in = 32'hFF;
      step(1);
      we = '0;
      addr_in = '0;
      step(8);
      chk("we1_tx_high", 32'(tx), 32'd1);
      read_status("we1_status");
      chk("we1_status_const", data_out, 32'h4);
      check_window("we1_line");

      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 5);
         if (r == 0) read_status("rand_status");
         else if (r == 1) w1c();
         else begin
            step(r == 2 ? 0 : $urandom_range(0, 45));
            push_byte(8'($urandom));
         end
      end
      drain();
      check_window("rand_frames");
      read_status("rand_final_status");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
